// File: rtl/alu_exec_stage.sv
// alu_exec_stage: execute-stage sequencer in front of the ALU.
// Holds decoded operands stable for a fixed number of cycles (longer for
// mul/div/rem), captures the ALU result and hands it to writeback.
// Ports: clock/reset (async, active-high)/flush; decode side in_*
// (valid/ready); ALU side alu_* out, alu_result/alu_zero in; writeback
// side out_* (valid/ready); busy = not idle.
module alu_exec_stage #(
   parameter int MULDIV_CYCLES = 4,
   parameter int BASIC_CYCLES  = 1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        flush,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_data1,
   input  logic [31:0] in_data2,
   input  logic [3:0]  in_aluOp,
   input  logic [4:0]  in_shamt,
   input  logic [4:0]  in_rd,
   output logic [31:0] alu_data1,
   output logic [31:0] alu_data2,
   output logic [3:0]  alu_aluOp,
   output logic [4:0]  alu_shamt,
   input  logic [31:0] alu_result,
   input  logic        alu_zero,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_result,
   output logic        out_zero,
   output logic [4:0]  out_rd,
   output logic        out_divz,
   output logic        out_illegal,
   output logic        busy
);
   typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
   state_t      state_q;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] data1_q, data2_q, result_q, result_d;
   logic [3:0]  op_q;
   logic [4:0]  shamt_q, rd_q, out_rd_q;
   logic        divz_q, illegal_q, divz_d, illegal_d, muldiv_d;
   logic        out_valid_q, out_zero_q, out_divz_q, out_illegal_q;
   logic        accept;
   logic        unused_zero;
   // out_zero is always recomputed from the captured value, so alu_zero is not needed
   assign unused_zero = alu_zero;
   assign in_ready  = (state_q == IDLE) | ((state_q == DONE) & out_ready);
   assign accept    = in_valid & in_ready;
   assign divz_d    = ((in_aluOp == 4'b1101) | (in_aluOp == 4'b1110)) & (in_data2 == 32'd0);
   assign illegal_d = in_aluOp == 4'b1111;
   assign muldiv_d  = (in_aluOp >= 4'b1100) & (in_aluOp <= 4'b1110);
   // special cases skip the muldiv wait: their result never comes from the ALU
   assign cnt_d     = (muldiv_d & ~divz_d & ~illegal_d) ? 4'(MULDIV_CYCLES - 1) : 4'(BASIC_CYCLES - 1);
   // divz is only ever set for 1101/1110, so a non-1101 divz is the remainder case
   assign result_d  = (divz_q & (op_q == 4'b1101)) ? 32'hFFFF_FFFF :
                      divz_q ? data1_q : illegal_q ? 32'd0 : alu_result;
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         data1_q       <= '0;
         data2_q       <= '0;
         op_q          <= '0;
         shamt_q       <= '0;
         rd_q          <= '0;
         divz_q        <= 1'b0;
         illegal_q     <= 1'b0;
         out_valid_q   <= 1'b0;
         result_q      <= '0;
         out_zero_q    <= 1'b0;
         out_rd_q      <= '0;
         out_divz_q    <= 1'b0;
         out_illegal_q <= 1'b0;
      end else if (flush) begin
         state_q       <= IDLE;
         out_valid_q   <= 1'b0;
         out_divz_q    <= 1'b0;
         out_illegal_q <= 1'b0;
      end else if (accept) begin
         state_q     <= EXEC;
         out_valid_q <= 1'b0;
         data1_q     <= in_data1;
         data2_q     <= in_data2;
         op_q        <= in_aluOp;
         shamt_q     <= in_shamt;
         rd_q        <= in_rd;
         divz_q      <= divz_d;
         illegal_q   <= illegal_d;
         cnt_q       <= cnt_d;
      end else if (state_q == EXEC) begin
         if (cnt_q == 4'd0) begin
            state_q       <= DONE;
            out_valid_q   <= 1'b1;
            result_q      <= result_d;
            out_zero_q    <= result_d == 32'd0;
            out_rd_q      <= rd_q;
            out_divz_q    <= divz_q;
            out_illegal_q <= illegal_q;
         end else begin
            cnt_q <= cnt_q - 4'd1;
         end
      end else if ((state_q == DONE) & out_ready) begin
         state_q     <= IDLE;
         out_valid_q <= 1'b0;
      end
   end
   assign alu_data1   = data1_q;
   assign alu_data2   = data2_q;
   assign alu_aluOp   = op_q;
   assign alu_shamt   = shamt_q;
   assign out_valid   = out_valid_q;
   assign out_result  = result_q;
   assign out_zero    = out_zero_q;
   assign out_rd      = out_rd_q;
   assign out_divz    = out_divz_q;
   assign out_illegal = out_illegal_q;
   assign busy        = state_q != IDLE;
endmodule

// File: tb/tb_alu_exec_stage.sv
// tb_alu_exec_stage: directed + random checks of alu_exec_stage with a behavioural ALU.
module tb_alu_exec_stage;
   localparam int BAS = 1;
   localparam int MUL = 4;
   logic        clock = 1'b0, reset = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
   logic        in_ready, alu_zero, out_valid, out_zero, out_divz, out_illegal, busy;
   logic [31:0] in_data1 = '0, in_data2 = '0, alu_data1, alu_data2, alu_result, out_result;
   logic [3:0]  in_aluOp = '0, alu_aluOp;
   logic [4:0]  in_shamt = '0, in_rd = '0, alu_shamt, out_rd;
   int          total = 0, bad = 0;
   logic [31:0] e_a, e_b, e_res;
   logic [3:0]  e_op;
   logic [4:0]  e_sh, e_rd;
   logic        e_divz, e_ill;
   int          e_lat;
   alu_exec_stage #(.MULDIV_CYCLES(MUL), .BASIC_CYCLES(BAS)) dut (
      .clock(clock), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_data1(in_data1), .in_data2(in_data2), .in_aluOp(in_aluOp),
      .in_shamt(in_shamt), .in_rd(in_rd),
      .alu_data1(alu_data1), .alu_data2(alu_data2), .alu_aluOp(alu_aluOp),
      .alu_shamt(alu_shamt), .alu_result(alu_result), .alu_zero(alu_zero),
      .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
      .out_zero(out_zero), .out_rd(out_rd), .out_divz(out_divz),
      .out_illegal(out_illegal), .busy(busy)
   );
   always #5 clock = ~clock;
   // behavioural ALU; divide-by-zero and 1111 give deliberately wrong values
   function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh);
      case (op)
         4'd0:    return a;
         4'd1:    return a + b;
         4'd2:    return a - b;
         4'd3:    return a & b;
         4'd4:    return a | b;
         4'd5:    return a ^ b;
         4'd6:    return a << sh;
         4'd7:    return a >> sh;
         4'd12:   return a * b;
         4'd13:   return (b == 0) ? 32'd0 : a / b;
         4'd14:   return (b == 0) ? 32'd0 : a % b;
         4'd15:   return 32'hDEAD_BEEF;
         default: return a + {27'd0, sh};
      endcase
   endfunction
   always_comb begin
      alu_result = alu_fn(alu_aluOp, alu_data1, alu_data2, alu_shamt);
      alu_zero   = alu_result == 32'd0;
   end
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic step();
      @(posedge clock);
      #1;
   endtask
   // present an op, check it is taken on the next edge and reaches the ALU ports
   task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op, input logic [4:0] sh, input logic [4:0] rd);
      in_data1 = a; in_data2 = b; in_aluOp = op; in_shamt = sh; in_rd = rd; in_valid = 1'b1;
      e_a = a; e_b = b; e_op = op; e_sh = sh; e_rd = rd;
      e_divz = (op == 4'd13 || op == 4'd14) && b == 32'd0;
      e_ill  = op == 4'd15;
      e_res  = e_ill ? 32'd0 : (e_divz && op == 4'd13) ? 32'hFFFF_FFFF : e_divz ? a : alu_fn(op, a, b, sh);
      e_lat  = (!e_divz && !e_ill && op >= 4'd12 && op <= 4'd14) ? MUL : BAS;
      #1;
      chk("in_ready_accept", 64'(in_ready), 64'd1);
      step();
      in_valid = 1'b0;
      chk("alu_operands", {alu_data1, alu_data2}, {e_a, e_b});
      chk("alu_op_shamt", 64'({alu_aluOp, alu_shamt}), 64'({e_op, e_sh}));
      chk("busy_exec", 64'(busy), 64'd1);
      chk("out_valid_exec", 64'(out_valid), 64'd0);
   endtask
   task automatic finish_op();
      for (int k = 1; k <= e_lat; k++) begin
         step();
         chk("out_valid_latency", 64'(out_valid), 64'(k == e_lat));
         chk("alu_hold", {alu_data1, alu_data2}, {e_a, e_b});
         if (k < e_lat) chk("in_ready_exec", 64'(in_ready), 64'd0);
      end
      chk("out_result", 64'(out_result), 64'(e_res));
      chk("out_zero", 64'(out_zero), 64'(e_res == 32'd0));
      chk("out_rd", 64'(out_rd), 64'(e_rd));
      chk("out_divz", 64'(out_divz), 64'(e_divz));
      chk("out_illegal", 64'(out_illegal), 64'(e_ill));
   endtask
   task automatic drain();
      step();
      chk("out_valid_drop", 64'(out_valid), 64'd0);
      chk("busy_idle", 64'(busy), 64'd0);
   endtask
   initial begin
      logic [31:0] ra, rb;
      logic [3:0]  rop;
      repeat (2) @(posedge clock);
      #1;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_alu", {alu_data1, alu_data2}, 64'd0);
      chk("rst_alu_op", 64'({alu_aluOp, alu_shamt}), 64'd0);
      chk("rst_out", 64'({out_result, out_zero, out_rd, out_divz, out_illegal}), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      reset = 1'b0;
      step();
      issue(32'd5, 32'd3, 4'd1, 5'd0, 5'd7);
      finish_op();
      chk("busy_done", 64'(busy), 64'd1);
      drain();
      issue(32'd7, 32'd7, 4'd2, 5'd0, 5'd3);
      finish_op();
      drain();
      issue(32'd6, 32'd7, 4'd12, 5'd0, 5'd9);
      finish_op();
      drain();
      issue(32'd10, 32'd0, 4'd13, 5'd0, 5'd1);
      finish_op();
      drain();
      issue(32'd10, 32'd0, 4'd14, 5'd0, 5'd2);
      finish_op();
      drain();
      issue(32'd1, 32'd2, 4'd15, 5'd0, 5'd4);
      finish_op();
      drain();
      out_ready = 1'b0;
      issue(32'd9, 32'd4, 4'd12, 5'd0, 5'd5);
      finish_op();
      for (int i = 0; i < 3; i++) begin
         step();
         chk("bp_valid", 64'(out_valid), 64'd1);
         chk("bp_result", 64'({out_result, out_rd}), 64'({32'd36, 5'd5}));
         chk("bp_in_ready", 64'(in_ready), 64'd0);
      end
      out_ready = 1'b1;
      issue(32'd100, 32'd20, 4'd2, 5'd0, 5'd6);
      finish_op();
      drain();
      issue(32'd3, 32'd5, 4'd12, 5'd0, 5'd2);
      step();
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("flush_valid", 64'(out_valid), 64'd0);
      chk("flush_busy", 64'(busy), 64'd0);
      chk("flush_in_ready", 64'(in_ready), 64'd1);
      chk("flush_alu_keep", {alu_data1, alu_data2}, {32'd3, 32'd5});
      for (int i = 0; i < 4; i++) begin
         step();
         chk("flush_no_valid", 64'(out_valid), 64'd0);
      end
      in_data1 = 32'd77; in_aluOp = 4'd1; in_valid = 1'b1; flush = 1'b1;
      step();
      in_valid = 1'b0; flush = 1'b0;
      chk("flush_no_accept", 64'(busy), 64'd0);
      chk("flush_no_load", 64'(alu_data1), 64'd3);
      out_ready = 1'b0;
      issue(32'd10, 32'd0, 4'd13, 5'd0, 5'd8);
      finish_op();
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("flush_done_flags", 64'({out_valid, out_divz, out_illegal, busy}), 64'd0);
      out_ready = 1'b1;
      for (int n = 0; n < 40; n++) begin
         ra  = $urandom;
         rb  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
         rop = 4'($urandom_range(0, 15));
         issue(ra, rb, rop, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
         finish_op();
         drain();
      end
      out_ready = 1'b0;
      issue(32'd4, 32'd4, 4'd1, 5'd0, 5'd11);
      finish_op();
      #2;
      reset = 1'b1;
      #1;
      chk("async_rst_valid", 64'(out_valid), 64'd0);
      chk("async_rst_busy", 64'(busy), 64'd0);
      chk("async_rst_out", 64'({out_result, out_rd}), 64'd0);
      #1;
      reset = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("rst_no_replay", 64'({out_valid, busy}), 64'd0);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/alu_exec_stage.md
Name: alu_exec_stage

Overview:
- Execute-stage sequencer directly upstream of the ALU.
- Accepts decoded operations from the decode stage over a valid/ready handshake and registers the ALU operands, holding them stable for a fixed number of cycles.
- Captures aluOut/zero and presents the result to writeback with a valid/ready handshake.
- Makes multiply, divide and remainder multicycle paths, and intercepts divide-by-zero and undefined opcodes so the ALU never produces X results downstream.

Parameters:
- MULDIV_CYCLES, 4, EXEC cycles for aluOp 1100/1101/1110; legal range 1..15.
- BASIC_CYCLES, 1, EXEC cycles for every other opcode; legal range 1..15.

Ports:
- clock  in  1  single clock for the whole block (only clock).
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous kill of the in-flight op.
- in_valid  in  1  decode presents an op.
- in_ready  out  1  stage can accept.
- in_data1  in  32  operand 1.
- in_data2  in  32  operand 2.
- in_aluOp  in  4  ALU opcode.
- in_shamt  in  5  shift amount.
- in_rd  in  5  destination register tag.
- alu_data1  out  32  registered operand to ALU data1.
- alu_data2  out  32  registered operand to ALU data2.
- alu_aluOp  out  4  registered opcode to ALU cu_aluOp.
- alu_shamt  out  5  registered shift amount to ALU shamt.
- alu_result  in  32  ALU aluOut.
- alu_zero  in  1  ALU zero.
- out_valid  out  1  result valid.
- out_ready  in  1  writeback accepts.
- out_result  out  32  captured result.
- out_zero  out  1  result == 0.
- out_rd  out  5  destination tag.
- out_divz  out  1  divide or remainder by zero occurred.
- out_illegal  out  1  opcode 1111 received.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (async, active-high) clears all registered outputs and the FSM:
  - state = IDLE.
  - alu_* = 0 (aluOp 0000 = pass).
  - out_* = 0, out_valid = 0, busy = 0.
  - The op counter is cleared.
- FSM states: IDLE, EXEC, DONE.
- in_ready = (state == IDLE) | (state == DONE & out_ready). It is combinational and never depends on in_valid.
- Accept = in_valid & in_ready. On accept:
  - Load alu_* from in_*.
  - Latch in_rd and the special-case flags.
  - Load cnt = (opcode in 1100..1110 ? MULDIV_CYCLES : BASIC_CYCLES) - 1.
  - Go to EXEC.
- Special-case flags, evaluated at accept:
  - divz = (op == 1101 | op == 1110) & in_data2 == 0.
  - illegal = (op == 1111).
  - When either flag is set, cnt loads BASIC_CYCLES - 1 (no muldiv wait).
- EXEC:
  - alu_* stay constant.
  - cnt decrements each cycle.
  - On the edge where cnt == 0, capture the result and go to DONE with out_valid = 1.
- Capture mux:
  - divz & op 1101: result = 32'hFFFFFFFF.
  - divz & op 1110: result = alu_data1.
  - illegal: result = 0.
  - otherwise: result = alu_result.
  - out_zero = (captured result == 0). It is recomputed locally, never taken from alu_zero, on the special paths.
- Latency: a basic op accepted at edge E0 gives out_valid high after edge E0 + BASIC_CYCLES. A muldiv op gives E0 + MULDIV_CYCLES.
- DONE holds out_* stable while out_ready = 0.
  - out_ready = 1 without accept: out_valid drops next edge, go to IDLE.
  - out_ready = 1 with simultaneous accept: the new op loads and goes to EXEC. This gives back-to-back throughput of one op per (cycles + 1).
- flush:
  - Synchronous; highest priority after reset.
  - Next edge: state = IDLE, out_valid = 0, out_divz = out_illegal = 0.
  - alu_* keep their last values.
  - A flush coincident with in_valid does not accept the op.
- Reset mid-EXEC or mid-DONE: the op is discarded and is not replayed.
- Arithmetic is all done by the ALU; this block only selects values, compares to zero and counts.

Test Plan:
- Reset, BASIC_CYCLES = 1: accept op 0001, 5 + 3, rd = 7 -> out_valid one cycle later, out_result = 8, out_zero = 0, out_rd = 7, busy high 2 cycles.
- Op 0010, 7 - 7 -> out_result = 0, out_zero = 1; in_ready = 0 throughout EXEC.
- MULDIV_CYCLES = 4, op 1100, 6 * 7 -> alu_* stable for 4 cycles, out_valid exactly 4 cycles after accept, out_result = 42.
- Op 1101, 10 / 0 -> 32'hFFFFFFFF, out_divz = 1. Op 1110, 10 % 0 -> 10, out_divz = 1. Both after BASIC_CYCLES. Op 1111 -> 0, out_illegal = 1, out_zero = 1.
- Back-pressure: hold out_ready = 0 for 3 cycles -> out_* unchanged. Then raise out_ready with in_valid = 1 -> same-edge handoff, new op accepted, no bubble in in_ready.
- Flush and reset:
  - flush asserted during muldiv EXEC -> IDLE next edge, no out_valid.
  - Async reset pulsed mid-cycle during DONE -> out_valid = 0 immediately, before the next clock edge.
